// File: rtl/rs_csr_queue.sv
// CSR reservation station: a circular, age-ordered buffer of CSR micro-ops.
// Each entry waits for its single source tag, then issues through a registered valid/ready port.
module rs_csr_queue #(
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 8,
    parameter int NUM_WB   = 7,
    parameter int IN_ORDER = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [31:0]                alloc_inst_num,
    input  logic [TAG_W-1:0]           alloc_rd,
    input  logic [3:0]                 alloc_aluop,
    input  logic [31:0]                alloc_csr_data,
    input  logic [11:0]                alloc_csr_addr,
    input  logic [31:0]                alloc_imm,
    input  logic                       alloc_alusrc2,
    input  logic [TAG_W-1:0]           alloc_src_tag,
    input  logic                       alloc_src_ready,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [31:0]                issue_inst_num,
    output logic [TAG_W-1:0]           issue_rd,
    output logic [3:0]                 issue_aluop,
    output logic [31:0]                issue_csr_data,
    output logic [11:0]                issue_csr_addr,
    output logic [31:0]                issue_imm,
    output logic                       issue_alusrc2,
    output logic [TAG_W-1:0]           issue_src_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0]      inst_num;
        logic [TAG_W-1:0] rd;
        logic [3:0]       aluop;
        logic [31:0]      csr_data;
        logic [11:0]      csr_addr;
        logic [31:0]      imm;
        logic             alusrc2;
        logic [TAG_W-1:0] src_tag;
    } entry_t;

    entry_t             slot_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   rdy_q;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    entry_t             issue_q;

    entry_t             alloc_entry;
    logic               alloc_fire;
    logic               alloc_wake;
    logic [DEPTH-1:0]   wake_match;
    logic [DEPTH-1:0]   eligible;
    logic               cand_found;
    logic [PTR_W-1:0]   cand_idx;
    logic               issue_fire;
    logic [DEPTH-1:0]   valid_after;
    logic [CNT_W-1:0]   adv;
    logic               adv_stop;
    logic [PTR_W-1:0]   scan_idx;
    logic [CNT_W-1:0]   count_next;

    assign alloc_ready = (count < CNT_W'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign alloc_entry = '{
        inst_num: alloc_inst_num,
        rd:       alloc_rd,
        aluop:    alloc_aluop,
        csr_data: alloc_csr_data,
        csr_addr: alloc_csr_addr,
        imm:      alloc_imm,
        alusrc2:  alloc_alusrc2,
        src_tag:  alloc_src_tag
    };

    // Tag snooping: one comparator per (entry, channel) plus one set for the incoming op.
    always_comb begin
        alloc_wake = 1'b0;
        wake_match = '0;
        for (int c = 0; c < NUM_WB; c++) begin
            if (wb_valid[c] && (wb_tag[c*TAG_W +: TAG_W] == alloc_src_tag))
                alloc_wake = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_valid[c] && (wb_tag[c*TAG_W +: TAG_W] == slot_q[i].src_tag))
                    wake_match[i] = 1'b1;
            end
        end
        eligible = valid_q & (rdy_q | wake_match);
    end

    // Candidate selection: head only when in-order, else oldest eligible within the occupied window.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = head;
        scan_idx   = head;
        if (IN_ORDER != 0) begin
            cand_found = eligible[head];
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                scan_idx = head + PTR_W'(k);
                if (!cand_found && (k < int'(count)) && eligible[scan_idx]) begin
                    cand_found = 1'b1;
                    cand_idx   = scan_idx;
                end
            end
        end
        issue_fire = cand_found && (!issue_valid || issue_ready);
    end

    // Head skips every leading hole left after this cycle's issue; capacity returns only then.
    always_comb begin
        valid_after = valid_q;
        if (issue_fire)
            valid_after[cand_idx] = 1'b0;
        adv      = '0;
        adv_stop = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!adv_stop && (k < int'(count)) && !valid_after[head + PTR_W'(k)])
                adv = adv + CNT_W'(1);
            else
                adv_stop = 1'b1;
        end
        count_next = count - adv + CNT_W'(alloc_fire);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q     <= '0;
            rdy_q       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            issue_valid <= 1'b0;
            issue_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && wake_match[i])
                    rdy_q[i] <= 1'b1;
            end
            valid_q <= valid_after;
            if (alloc_fire) begin
                valid_q[tail] <= 1'b1;
                rdy_q[tail]   <= alloc_src_ready || alloc_wake;
                tail          <= tail + PTR_W'(1);
            end
            if (issue_fire) begin
                issue_q     <= slot_q[cand_idx];
                issue_valid <= 1'b1;
            end else if (issue_ready) begin
                issue_valid <= 1'b0;
            end
            head  <= head + PTR_W'(adv);
            count <= count_next;
        end
    end

    // Payload storage carries no reset; valid_q alone decides whether a slot means anything.
    always_ff @(posedge clk) begin
        if (!(reset || flush) && alloc_fire)
            slot_q[tail] <= alloc_entry;
    end

    assign issue_inst_num = issue_q.inst_num;
    assign issue_rd       = issue_q.rd;
    assign issue_aluop    = issue_q.aluop;
    assign issue_csr_data = issue_q.csr_data;
    assign issue_csr_addr = issue_q.csr_addr;
    assign issue_imm      = issue_q.imm;
    assign issue_alusrc2  = issue_q.alusrc2;
    assign issue_src_tag  = issue_q.src_tag;

endmodule

// File: tb/tb_rs_csr_queue.sv
// Directed bench for rs_csr_queue: an in-order and an oldest-ready instance share all stimulus.
module tb_rs_csr_queue;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 8;
    localparam int NUM_WB = 7;

    logic                    clk = 1'b0;
    logic                    reset, flush;
    logic                    alloc_valid;
    logic [31:0]             alloc_inst_num;
    logic [TAG_W-1:0]        alloc_rd;
    logic [3:0]              alloc_aluop;
    logic [31:0]             alloc_csr_data;
    logic [11:0]             alloc_csr_addr;
    logic [31:0]             alloc_imm;
    logic                    alloc_alusrc2;
    logic [TAG_W-1:0]        alloc_src_tag;
    logic                    alloc_src_ready;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic                    issue_ready;

    logic                    alloc_ready, issue_valid, issue_alusrc2;
    logic [31:0]             issue_inst_num, issue_csr_data, issue_imm;
    logic [TAG_W-1:0]        issue_rd, issue_src_tag;
    logic [3:0]              issue_aluop;
    logic [11:0]             issue_csr_addr;
    logic [4:0]              count;

    logic                    o_alloc_ready, o_issue_valid, o_issue_alusrc2;
    logic [31:0]             o_issue_inst_num, o_issue_csr_data, o_issue_imm;
    logic [TAG_W-1:0]        o_issue_rd, o_issue_src_tag;
    logic [3:0]              o_issue_aluop;
    logic [11:0]             o_issue_csr_addr;
    logic [4:0]              o_count;

    int checks = 0;
    int passes = 0;

    rs_csr_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .IN_ORDER(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_inst_num(alloc_inst_num), .alloc_rd(alloc_rd), .alloc_aluop(alloc_aluop),
        .alloc_csr_data(alloc_csr_data), .alloc_csr_addr(alloc_csr_addr), .alloc_imm(alloc_imm),
        .alloc_alusrc2(alloc_alusrc2), .alloc_src_tag(alloc_src_tag), .alloc_src_ready(alloc_src_ready),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_inst_num(issue_inst_num), .issue_rd(issue_rd), .issue_aluop(issue_aluop),
        .issue_csr_data(issue_csr_data), .issue_csr_addr(issue_csr_addr), .issue_imm(issue_imm),
        .issue_alusrc2(issue_alusrc2), .issue_src_tag(issue_src_tag), .count(count)
    );

    rs_csr_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .IN_ORDER(0)) dut_ooo (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(o_alloc_ready),
        .alloc_inst_num(alloc_inst_num), .alloc_rd(alloc_rd), .alloc_aluop(alloc_aluop),
        .alloc_csr_data(alloc_csr_data), .alloc_csr_addr(alloc_csr_addr), .alloc_imm(alloc_imm),
        .alloc_alusrc2(alloc_alusrc2), .alloc_src_tag(alloc_src_tag), .alloc_src_ready(alloc_src_ready),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_valid(o_issue_valid), .issue_ready(issue_ready),
        .issue_inst_num(o_issue_inst_num), .issue_rd(o_issue_rd), .issue_aluop(o_issue_aluop),
        .issue_csr_data(o_issue_csr_data), .issue_csr_addr(o_issue_csr_addr), .issue_imm(o_issue_imm),
        .issue_alusrc2(o_issue_alusrc2), .issue_src_tag(o_issue_src_tag), .count(o_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic v, input logic [31:0] inst, input logic [7:0] tag, input logic rdy);
        alloc_valid     = v;
        alloc_inst_num  = inst;
        alloc_rd        = inst[7:0] + 8'h40;
        alloc_aluop     = inst[3:0];
        alloc_csr_data  = inst ^ 32'hA5A5_0000;
        alloc_csr_addr  = 12'h300 + inst[11:0];
        alloc_imm       = inst + 32'd7;
        alloc_alusrc2   = inst[0];
        alloc_src_tag   = tag;
        alloc_src_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_alloc(1'b0, 32'd0, 8'd0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        flush = 1'b0; wb_valid = '0; wb_tag = '0; issue_ready = 1'b0;
        do_reset();
        checks++; if ({issue_valid, count, alloc_ready} !== {1'b0, 5'd0, 1'b1})
            $display("FAIL reset_state: got v=%0b cnt=%0d ar=%0b need 0 0 1", issue_valid, count, alloc_ready);
            else passes++;
        checks++; if ({issue_inst_num, issue_rd, issue_imm} !== '0)
            $display("FAIL reset_payload: got inst=%0h rd=%0h imm=%0h need 0", issue_inst_num, issue_rd, issue_imm);
            else passes++;
    endtask

    task automatic test_basic_stream();
        do_reset();
        issue_ready = 1'b1;
        set_alloc(1'b1, 32'd10, 8'h01, 1'b1); tick();
        checks++; if ({issue_valid, count} !== {1'b0, 5'd1})
            $display("FAIL basic_latency: got v=%0b cnt=%0d need v=0 cnt=1", issue_valid, count);
            else passes++;
        set_alloc(1'b1, 32'd11, 8'h01, 1'b1); tick();
        checks++; if ({issue_valid, issue_inst_num} !== {1'b1, 32'd10})
            $display("FAIL basic_issue0: got v=%0b inst=%0d need 1 10", issue_valid, issue_inst_num);
            else passes++;
        checks++; if ({issue_rd, issue_csr_addr, issue_imm} !== {8'h4A, 12'h30A, 32'd17})
            $display("FAIL basic_payload: got rd=%0h addr=%0h imm=%0d need 4a 30a 17", issue_rd, issue_csr_addr, issue_imm);
            else passes++;
        set_alloc(1'b1, 32'd12, 8'h01, 1'b1); tick();
        checks++; if ({issue_valid, issue_inst_num, count} !== {1'b1, 32'd11, 5'd1})
            $display("FAIL basic_issue1: got v=%0b inst=%0d cnt=%0d need 1 11 1", issue_valid, issue_inst_num, count);
            else passes++;
        set_alloc(1'b0, 32'd0, 8'h00, 1'b0); tick();
        checks++; if ({issue_valid, issue_inst_num, count} !== {1'b1, 32'd12, 5'd0})
            $display("FAIL basic_issue2: got v=%0b inst=%0d cnt=%0d need 1 12 0", issue_valid, issue_inst_num, count);
            else passes++;
        tick();
        checks++; if (issue_valid !== 1'b0)
            $display("FAIL basic_drain: got v=%0b need 0", issue_valid);
            else passes++;
    endtask

    task automatic test_wakeup_order();
        do_reset();
        issue_ready = 1'b1;
        set_alloc(1'b1, 32'd20, 8'h05, 1'b0); tick();
        set_alloc(1'b1, 32'd21, 8'h06, 1'b1); tick();
        checks++; if ({issue_valid, o_issue_valid} !== 2'b00)
            $display("FAIL wake_none_yet: got io=%0b ooo=%0b need 0 0", issue_valid, o_issue_valid);
            else passes++;
        set_alloc(1'b0, 32'd0, 8'h00, 1'b0); tick();
        checks++; if ({issue_valid, count} !== {1'b0, 5'd2})
            $display("FAIL inorder_blocked: got v=%0b cnt=%0d need 0 2", issue_valid, count);
            else passes++;
        checks++; if ({o_issue_valid, o_issue_inst_num, o_count} !== {1'b1, 32'd21, 5'd2})
            $display("FAIL ooo_young_first: got v=%0b inst=%0d cnt=%0d need 1 21 2", o_issue_valid, o_issue_inst_num, o_count);
            else passes++;
        wb_valid = 7'b000_0100;
        wb_tag   = 56'h05 << (2 * TAG_W);
        tick();
        wb_valid = '0; wb_tag = '0;
        checks++; if ({issue_valid, issue_inst_num, count} !== {1'b1, 32'd20, 5'd1})
            $display("FAIL inorder_head_wake: got v=%0b inst=%0d cnt=%0d need 1 20 1", issue_valid, issue_inst_num, count);
            else passes++;
        checks++; if ({o_issue_valid, o_issue_inst_num, o_count} !== {1'b1, 32'd20, 5'd0})
            $display("FAIL ooo_head_wake: got v=%0b inst=%0d cnt=%0d need 1 20 0", o_issue_valid, o_issue_inst_num, o_count);
            else passes++;
        tick();
        checks++; if ({issue_valid, issue_inst_num, count} !== {1'b1, 32'd21, 5'd0})
            $display("FAIL inorder_second: got v=%0b inst=%0d cnt=%0d need 1 21 0", issue_valid, issue_inst_num, count);
            else passes++;
        checks++; if (o_issue_valid !== 1'b0)
            $display("FAIL ooo_drained: got v=%0b need 0", o_issue_valid);
            else passes++;
    endtask

    task automatic test_full();
        do_reset();
        issue_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            set_alloc(1'b1, 32'd100 + 32'(k), 8'h02, 1'b1);
            tick();
        end
        checks++; if ({count, alloc_ready, issue_valid, issue_inst_num} !== {5'd16, 1'b0, 1'b1, 32'd100})
            $display("FAIL full_state: got cnt=%0d ar=%0b v=%0b inst=%0d need 16 0 1 100", count, alloc_ready, issue_valid, issue_inst_num);
            else passes++;
        set_alloc(1'b1, 32'd200, 8'h02, 1'b1); tick();
        checks++; if (count !== 5'd16)
            $display("FAIL full_ignore: got cnt=%0d need 16", count);
            else passes++;
        issue_ready = 1'b1; tick();
        checks++; if ({count, alloc_ready, issue_inst_num} !== {5'd15, 1'b1, 32'd101})
            $display("FAIL full_reopen: got cnt=%0d ar=%0b inst=%0d need 15 1 101", count, alloc_ready, issue_inst_num);
            else passes++;
        issue_ready = 1'b0;
        set_alloc(1'b1, 32'd300, 8'h02, 1'b1); tick();
        checks++; if (count !== 5'd16)
            $display("FAIL full_refill: got cnt=%0d need 16", count);
            else passes++;
        set_alloc(1'b0, 32'd0, 8'h00, 1'b0);
        issue_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++; if (issue_inst_num !== ((k < 15) ? 32'd102 + 32'(k) : 32'd300))
                $display("FAIL full_drain_%0d: got inst=%0d need %0d", k, issue_inst_num, (k < 15) ? 102 + k : 300);
                else passes++;
        end
        tick();
        checks++; if ({issue_valid, count} !== {1'b0, 5'd0})
            $display("FAIL full_empty: got v=%0b cnt=%0d need 0 0", issue_valid, count);
            else passes++;
    endtask

    task automatic test_alloc_bypass();
        do_reset();
        issue_ready = 1'b1;
        set_alloc(1'b1, 32'd40, 8'h21, 1'b0);
        wb_valid = 7'b100_0000;
        wb_tag   = 56'h21 << (6 * TAG_W);
        tick();
        wb_valid = '0; wb_tag = '0;
        set_alloc(1'b1, 32'd41, 8'h22, 1'b0);
        checks++; if ({issue_valid, count} !== {1'b0, 5'd1})
            $display("FAIL bypass_stored: got v=%0b cnt=%0d need 0 1", issue_valid, count);
            else passes++;
        tick();
        set_alloc(1'b0, 32'd0, 8'h00, 1'b0);
        checks++; if ({issue_valid, issue_inst_num, issue_src_tag} !== {1'b1, 32'd40, 8'h21})
            $display("FAIL bypass_issue: got v=%0b inst=%0d tag=%0h need 1 40 21", issue_valid, issue_inst_num, issue_src_tag);
            else passes++;
        tick(); tick();
        checks++; if ({issue_valid, count} !== {1'b0, 5'd1})
            $display("FAIL unwoken_waits: got v=%0b cnt=%0d need 0 1", issue_valid, count);
            else passes++;
    endtask

    task automatic test_flush();
        do_reset();
        issue_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_alloc(1'b1, 32'd50 + 32'(k), 8'h03, 1'b1);
            tick();
        end
        checks++; if ({issue_valid, count} !== {1'b1, 5'd5})
            $display("FAIL flush_pre: got v=%0b cnt=%0d need 1 5", issue_valid, count);
            else passes++;
        flush = 1'b1;
        set_alloc(1'b1, 32'd60, 8'h03, 1'b1);
        tick();
        flush = 1'b0;
        set_alloc(1'b0, 32'd0, 8'h00, 1'b0);
        checks++; if ({issue_valid, count, alloc_ready, issue_inst_num} !== {1'b0, 5'd0, 1'b1, 32'd0})
            $display("FAIL flush_clear: got v=%0b cnt=%0d ar=%0b inst=%0d need 0 0 1 0", issue_valid, count, alloc_ready, issue_inst_num);
            else passes++;
        tick();
        checks++; if ({issue_valid, count} !== {1'b0, 5'd0})
            $display("FAIL flush_drop_alloc: got v=%0b cnt=%0d need 0 0", issue_valid, count);
            else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_wakeup_order();
        test_full();
        test_alloc_bypass();
        test_flush();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
